// File: rtl/srm_pkg.sv
// Shared SRM types: sequencer states, ISA field constants, datapath select encodings.
// Pure declarations; no timing or flow control of its own.
package srm_pkg;

    typedef enum logic [4:0] {
        S_WAIT,
        S_RST,
        S_FETCH,
        S_LOAD_IR,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_EXEC_CMP,
        S_WR_C,
        S_ADDR,
        S_LD_ADDR,
        S_MEM_RD,
        S_WR_MEM,
        S_GET_D,
        S_PASS,
        S_MEM_WR,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [2:0] OP_LDR  = 3'b011;
    localparam logic [2:0] OP_STR  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;
    localparam logic [1:0] MEM_OFF = 2'b00;

    localparam logic [1:0] REG_RM = 2'b00;
    localparam logic [1:0] REG_RD = 2'b01;
    localparam logic [1:0] REG_RN = 2'b10;

    localparam logic [1:0] WB_C     = 2'b00;
    localparam logic [1:0] WB_PC    = 2'b01;
    localparam logic [1:0] WB_IMM   = 2'b10;
    localparam logic [1:0] WB_MDATA = 2'b11;

    typedef struct packed {
        logic       waiting;
        logic       halted;
        logic [1:0] reg_sel;
        logic [1:0] wb_sel;
        logic       w_en;
        logic       en_A;
        logic       en_B;
        logic       en_C;
        logic       en_status;
        logic       sel_A;
        logic       sel_B;
        logic       clear_pc;
        logic       load_pc;
        logic       load_ir;
        logic       load_addr;
        logic       sel_addr;
        logic       ram_w_en;
    } ctrl_t;

    // First execute state for a freshly loaded instruction; anything unlisted halts.
    function automatic state_t dispatch(input logic [2:0] op, input logic [1:0] alu);
        state_t s;
        s = S_HALT;
        if (op == OP_MOV && alu == MOV_IMM)
            s = S_WR_IMM;
        else if (op == OP_MOV && alu == MOV_REG)
            s = S_GET_B;
        else if (op == OP_ALU)
            s = S_GET_A;
        else if ((op == OP_LDR || op == OP_STR) && alu == MEM_OFF)
            s = S_GET_A;
        return s;
    endfunction

endpackage

// File: rtl/srm_sequencer_if.sv
// Sequencer boundary: instruction fields in, Moore control strobes out.
// Combinational bundle; no handshake, the sequencer never stalls.
interface srm_sequencer_if;
    logic       start;
    logic [2:0] opcode;
    logic [1:0] ALU_op;
    logic       waiting;
    logic       halted;
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       w_en;
    logic       en_A;
    logic       en_B;
    logic       en_C;
    logic       en_status;
    logic       sel_A;
    logic       sel_B;
    logic       clear_pc;
    logic       load_pc;
    logic       load_ir;
    logic       load_addr;
    logic       sel_addr;
    logic       ram_w_en;

    modport slave (
        input  start, opcode, ALU_op,
        output waiting, halted, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
               sel_A, sel_B, clear_pc, load_pc, load_ir, load_addr, sel_addr, ram_w_en
    );

    modport master (
        output start, opcode, ALU_op,
        input  waiting, halted, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
               sel_A, sel_B, clear_pc, load_pc, load_ir, load_addr, sel_addr, ram_w_en
    );
endinterface

// File: rtl/srm_ctrl_decode.sv
// State to control-vector decoder for the SRM sequencer.
// Purely combinational, zero latency; no flow control.
module srm_ctrl_decode
    import srm_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mov_reg,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_WAIT:     o_ctrl.waiting = 1'b1;
            S_RST: begin
                o_ctrl.clear_pc = 1'b1;
                o_ctrl.load_pc  = 1'b1;
            end
            S_FETCH:    o_ctrl.sel_addr = 1'b1;
            S_LOAD_IR: begin
                o_ctrl.sel_addr = 1'b1;
                o_ctrl.load_ir  = 1'b1;
                o_ctrl.load_pc  = 1'b1;
            end
            S_DECODE:   ;
            S_WR_IMM: begin
                o_ctrl.reg_sel = REG_RN;
                o_ctrl.wb_sel  = WB_IMM;
                o_ctrl.w_en    = 1'b1;
            end
            S_GET_A: begin
                o_ctrl.reg_sel = REG_RN;
                o_ctrl.en_A    = 1'b1;
            end
            S_GET_B: begin
                o_ctrl.reg_sel = REG_RM;
                o_ctrl.en_B    = 1'b1;
            end
            // MOV Rd,Rm reuses the ALU path with A forced to zero.
            S_EXEC: begin
                o_ctrl.en_C  = 1'b1;
                o_ctrl.sel_A = i_mov_reg;
            end
            S_EXEC_CMP: o_ctrl.en_status = 1'b1;
            S_WR_C: begin
                o_ctrl.reg_sel = REG_RD;
                o_ctrl.wb_sel  = WB_C;
                o_ctrl.w_en    = 1'b1;
            end
            S_ADDR: begin
                o_ctrl.sel_B = 1'b1;
                o_ctrl.en_C  = 1'b1;
            end
            S_LD_ADDR:  o_ctrl.load_addr = 1'b1;
            S_MEM_RD:   ;
            S_WR_MEM: begin
                o_ctrl.reg_sel = REG_RD;
                o_ctrl.wb_sel  = WB_MDATA;
                o_ctrl.w_en    = 1'b1;
            end
            S_GET_D: begin
                o_ctrl.reg_sel = REG_RD;
                o_ctrl.en_B    = 1'b1;
            end
            S_PASS: begin
                o_ctrl.sel_A = 1'b1;
                o_ctrl.en_C  = 1'b1;
            end
            S_MEM_WR:   o_ctrl.ram_w_en = 1'b1;
            S_HALT:     o_ctrl.halted   = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: rtl/srm_sequencer.sv
// SRM multi-cycle control FSM: fetch/decode/execute, 4-9 cycles per instruction.
// Moore outputs from the state register; never stalls, only rst_n leaves HALT.
module srm_sequencer
    import srm_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    srm_sequencer_if.slave ctl
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_mov_reg;
    logic   w_mov_reg_nxt;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_WAIT;
            r_mov_reg <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mov_reg <= w_mov_reg_nxt;
        end
    end

    // Instruction class is remembered at DECODE so EXEC stays a pure state decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_mov_reg_nxt = r_mov_reg;
        case (r_state)
            S_WAIT:     if (ctl.start) w_state_nxt = S_RST;
            S_RST:      w_state_nxt = S_FETCH;
            S_FETCH:    w_state_nxt = S_LOAD_IR;
            S_LOAD_IR:  w_state_nxt = S_DECODE;
            S_DECODE: begin
                w_state_nxt   = dispatch(ctl.opcode, ctl.ALU_op);
                w_mov_reg_nxt = (ctl.opcode == OP_MOV);
            end
            S_GET_A:    w_state_nxt = (ctl.opcode == OP_ALU) ? S_GET_B : S_ADDR;
            S_GET_B:    w_state_nxt = (ctl.opcode == OP_ALU && ctl.ALU_op == ALU_CMP)
                                      ? S_EXEC_CMP : S_EXEC;
            S_EXEC:     w_state_nxt = S_WR_C;
            S_ADDR:     w_state_nxt = S_LD_ADDR;
            S_LD_ADDR:  w_state_nxt = (ctl.opcode == OP_LDR) ? S_MEM_RD : S_GET_D;
            S_MEM_RD:   w_state_nxt = S_WR_MEM;
            S_GET_D:    w_state_nxt = S_PASS;
            S_PASS:     w_state_nxt = S_MEM_WR;
            S_WR_IMM,
            S_WR_C,
            S_EXEC_CMP,
            S_WR_MEM,
            S_MEM_WR:   w_state_nxt = S_FETCH;
            S_HALT:     w_state_nxt = S_HALT;
            default:    w_state_nxt = S_WAIT;
        endcase
    end

    srm_ctrl_decode u_decode (
        .i_state   (r_state),
        .i_mov_reg (r_mov_reg),
        .o_ctrl    (w_ctrl)
    );

    assign ctl.waiting   = w_ctrl.waiting;
    assign ctl.halted    = w_ctrl.halted;
    assign ctl.reg_sel   = w_ctrl.reg_sel;
    assign ctl.wb_sel    = w_ctrl.wb_sel;
    assign ctl.w_en      = w_ctrl.w_en;
    assign ctl.en_A      = w_ctrl.en_A;
    assign ctl.en_B      = w_ctrl.en_B;
    assign ctl.en_C      = w_ctrl.en_C;
    assign ctl.en_status = w_ctrl.en_status;
    assign ctl.sel_A     = w_ctrl.sel_A;
    assign ctl.sel_B     = w_ctrl.sel_B;
    assign ctl.clear_pc  = w_ctrl.clear_pc;
    assign ctl.load_pc   = w_ctrl.load_pc;
    assign ctl.load_ir   = w_ctrl.load_ir;
    assign ctl.load_addr = w_ctrl.load_addr;
    assign ctl.sel_addr  = w_ctrl.sel_addr;
    assign ctl.ram_w_en  = w_ctrl.ram_w_en;

endmodule

// File: tb/tb_srm_sequencer.sv
// Bench for srm_sequencer: random instruction streams and random mid-instruction
// resets compared cycle by cycle against a per-instruction timeline model.
module tb_srm_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    srm_sequencer_if ctl ();

    srm_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ctl)
    );

    typedef struct packed {
        logic       waiting;
        logic       halted;
        logic [1:0] reg_sel;
        logic [1:0] wb_sel;
        logic       w_en;
        logic       en_A;
        logic       en_B;
        logic       en_C;
        logic       en_status;
        logic       sel_A;
        logic       sel_B;
        logic       clear_pc;
        logic       load_pc;
        logic       load_ir;
        logic       load_addr;
        logic       sel_addr;
        logic       ram_w_en;
    } ov_t;

    typedef enum int {K_MOVI, K_MOVR, K_ALU, K_CMP, K_LDR, K_STR, K_HALT} kind_t;

    localparam int HALT_OBSERVE = 50;

    int n_checks = 0;
    int n_errors = 0;

    logic [4:0] legal [8] = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01,
                              5'b101_10, 5'b101_11, 5'b011_00, 5'b100_00};
    logic [4:0] illegal [6] = '{5'b011_01, 5'b000_00, 5'b110_01, 5'b100_10,
                                5'b001_11, 5'b010_00};

    function automatic ov_t sample();
        ov_t v;
        v.waiting   = ctl.waiting;
        v.halted    = ctl.halted;
        v.reg_sel   = ctl.reg_sel;
        v.wb_sel    = ctl.wb_sel;
        v.w_en      = ctl.w_en;
        v.en_A      = ctl.en_A;
        v.en_B      = ctl.en_B;
        v.en_C      = ctl.en_C;
        v.en_status = ctl.en_status;
        v.sel_A     = ctl.sel_A;
        v.sel_B     = ctl.sel_B;
        v.clear_pc  = ctl.clear_pc;
        v.load_pc   = ctl.load_pc;
        v.load_ir   = ctl.load_ir;
        v.load_addr = ctl.load_addr;
        v.sel_addr  = ctl.sel_addr;
        v.ram_w_en  = ctl.ram_w_en;
        return v;
    endfunction

    function automatic kind_t classify(input logic [2:0] op, input logic [1:0] alu);
        if (op == 3'b110 && alu == 2'b10) return K_MOVI;
        if (op == 3'b110 && alu == 2'b00) return K_MOVR;
        if (op == 3'b101) return (alu == 2'b01) ? K_CMP : K_ALU;
        if (op == 3'b011 && alu == 2'b00) return K_LDR;
        if (op == 3'b100 && alu == 2'b00) return K_STR;
        return K_HALT;
    endfunction

    function automatic int span(input kind_t k);
        case (k)
            K_MOVI:  return 4;
            K_MOVR:  return 6;
            K_ALU:   return 7;
            K_CMP:   return 6;
            K_LDR:   return 8;
            K_STR:   return 9;
            default: return 3 + HALT_OBSERVE;
        endcase
    endfunction

    // Expected outputs on cycle c of an instruction, counting FETCH as cycle 1.
    function automatic ov_t expect_at(input kind_t k, input int c);
        ov_t v = '0;
        if (c == 1) begin
            v.sel_addr = 1'b1;
        end else if (c == 2) begin
            v.sel_addr = 1'b1;
            v.load_ir  = 1'b1;
            v.load_pc  = 1'b1;
        end else if (c >= 4) begin
            case (k)
                K_MOVI: begin
                    v.reg_sel = 2'b10; v.wb_sel = 2'b10; v.w_en = 1'b1;
                end
                K_MOVR: begin
                    if (c == 4) v.en_B = 1'b1;
                    if (c == 5) begin v.en_C = 1'b1; v.sel_A = 1'b1; end
                    if (c == 6) begin v.reg_sel = 2'b01; v.w_en = 1'b1; end
                end
                K_ALU, K_CMP: begin
                    if (c == 4) begin v.reg_sel = 2'b10; v.en_A = 1'b1; end
                    if (c == 5) v.en_B = 1'b1;
                    if (c == 6) begin
                        if (k == K_CMP) v.en_status = 1'b1;
                        else            v.en_C = 1'b1;
                    end
                    if (c == 7) begin v.reg_sel = 2'b01; v.w_en = 1'b1; end
                end
                K_LDR, K_STR: begin
                    if (c == 4) begin v.reg_sel = 2'b10; v.en_A = 1'b1; end
                    if (c == 5) begin v.sel_B = 1'b1; v.en_C = 1'b1; end
                    if (c == 6) v.load_addr = 1'b1;
                    if (k == K_LDR && c == 8) begin
                        v.reg_sel = 2'b01; v.wb_sel = 2'b11; v.w_en = 1'b1;
                    end
                    if (k == K_STR && c == 7) begin v.reg_sel = 2'b01; v.en_B = 1'b1; end
                    if (k == K_STR && c == 8) begin v.sel_A = 1'b1; v.en_C = 1'b1; end
                    if (k == K_STR && c == 9) v.ram_w_en = 1'b1;
                end
                default: v.halted = 1'b1;
            endcase
        end
        return v;
    endfunction

    function automatic ov_t wait_vec();
        ov_t v = '0;
        v.waiting = 1'b1;
        return v;
    endfunction

    function automatic ov_t rst_vec();
        ov_t v = '0;
        v.clear_pc = 1'b1;
        v.load_pc  = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input ov_t got, input ov_t exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_excl(input string tag, input ov_t got);
        n_checks++;
        assert ((32'(got.w_en) + 32'(got.ram_w_en) + 32'(got.en_status)) <= 1) else begin
            n_errors++;
            $error("FAIL %s: write strobes w_en/ram_w_en/en_status = %b%b%b, at most one allowed",
                   tag, got.w_en, got.ram_w_en, got.en_status);
        end
    endtask

    // Called 1 time unit after a rising edge; asserts reset between edges.
    task automatic do_reset();
        ctl.start = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("reset_async", sample(), wait_vec());
        @(posedge clk); #1;
        check("reset_hold", sample(), wait_vec());
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_release", sample(), wait_vec());
    endtask

    task automatic do_start(input bit abort_in_rst);
        ctl.start = 1'b1;
        @(posedge clk); #1;
        ctl.start = 1'b0;
        check("start_rst", sample(), rst_vec());
        if (abort_in_rst) begin
            do_reset();
            ctl.start = 1'b1;
            @(posedge clk); #1;
            ctl.start = 1'b0;
            check("restart_rst", sample(), rst_vec());
        end
        @(posedge clk); #1;
    endtask

    // Entered 1 time unit after the edge into FETCH; abort_c = 0 runs to completion.
    task automatic run_instr(input logic [2:0] op, input logic [1:0] alu, input int abort_c);
        kind_t k = classify(op, alu);
        int    n = span(k);
        ctl.opcode = op;
        ctl.ALU_op = alu;
        for (int c = 1; c <= n; c++) begin
            ov_t got = sample();
            check($sformatf("op%b_%b_c%0d", op, alu, c), got, expect_at(k, c));
            check_excl($sformatf("excl_op%b_%b_c%0d", op, alu, c), got);
            if (c == abort_c) begin
                do_reset();
                return;
            end
            ctl.start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [4:0] ins;
        rst_n      = 1'b0;
        ctl.start  = 1'b0;
        ctl.opcode = 3'b000;
        ctl.ALU_op = 2'b00;
        #1 check("por", sample(), wait_vec());
        repeat (2) @(posedge clk);
        #1 check("por_clocked", sample(), wait_vec());
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_no_start", sample(), wait_vec());

        // Long random stream, closed by HALT with random start pulses ignored.
        do_start(1'b0);
        for (int i = 0; i < 8; i++) begin
            ins = legal[i];
            run_instr(ins[4:2], ins[1:0], 0);
        end
        repeat (40) begin
            ins = legal[$urandom_range(0, 7)];
            run_instr(ins[4:2], ins[1:0], 0);
        end
        run_instr(3'b111, 2'($urandom_range(0, 3)), 0);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            do_start(1'b0);
            ins = legal[$urandom_range(0, 7)];
            run_instr(ins[4:2], ins[1:0], 0);
            ins = illegal[i];
            run_instr(ins[4:2], ins[1:0], 0);
            do_reset();
        end

        do_start(1'b1);
        run_instr(3'b101, 2'b00, 0);
        do_reset();

        // Reset landing in every state of the longest instruction.
        for (int c = 1; c <= 9; c++) begin
            do_start(1'b0);
            run_instr(3'b100, 2'b00, c);
        end
        for (int c = 7; c <= 8; c++) begin
            do_start(1'b0);
            run_instr(3'b011, 2'b00, c);
        end

        repeat (40) begin
            int    c;
            kind_t k;
            do_start(1'b0);
            if ($urandom_range(0, 4) == 0) ins = {3'b111, 2'($urandom_range(0, 3))};
            else                           ins = legal[$urandom_range(0, 7)];
            k = classify(ins[4:2], ins[1:0]);
            c = $urandom_range(1, span(k));
            run_instr(ins[4:2], ins[1:0], c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/srm_sequencer.md
# srm_sequencer

Multi-cycle control FSM for the Simple RISC Machine core. Sequences fetch, decode and execute over the shared `datapath`, the instruction register, the PC/data-address registers and the single-port synchronous `ram`. Consumes opcode/ALU_op fields from `idecoder` and emits Moore control strobes, one state per datapath step.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  leave WAIT and begin execution at `start_pc`
- `opcode`  in  3  instr[15:13]
- `ALU_op`  in  2  instr[12:11]
- `waiting`  out  1  high in WAIT
- `halted`  out  1  high in HALT
- `reg_sel`  out  2  register-file index source: 00 Rm, 01 Rd, 10 Rn
- `wb_sel`  out  2  write-back source: 00 C, 01 PC, 10 sximm8, 11 mdata
- `w_en`, `en_A`, `en_B`, `en_C`, `en_status`  out  1 each  datapath enables
- `sel_A`  out  1  1 = ALU A operand forced to 0
- `sel_B`  out  1  1 = ALU B operand is sximm5
- `clear_pc`, `load_pc`  out  1 each  PC <= start_pc when both high; PC <= PC+1 when only `load_pc`
- `load_ir`  out  1  IR <= ram_r_data
- `load_addr`  out  1  data_address <= datapath_out[7:0]
- `sel_addr`  out  1  1 = RAM address is PC, 0 = data_address
- `ram_w_en`  out  1  RAM write strobe

## Operation
- Outputs are pure functions of the state register; any output not named for a state is 0.
- ISA: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{sh}; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN; 011/00 LDR Rd,[Rn,#imm5]; 100/00 STR Rd,[Rn,#imm5]; 111 HALT. Any other opcode/ALU_op combination is treated as HALT.
- States and outputs:
  - WAIT: `waiting`.
  - RST: `clear_pc`, `load_pc`.
  - FETCH: `sel_addr`.
  - LOAD_IR: `sel_addr`, `load_ir`, `load_pc`.
  - DECODE: none.
  - WR_IMM: `reg_sel`=10, `wb_sel`=10, `w_en`.
  - GET_A: `reg_sel`=10, `en_A`.
  - GET_B: `reg_sel`=00, `en_B`.
  - EXEC: `en_C`; `sel_A`=1 for MOV reg only.
  - EXEC_CMP: `en_status`.
  - WR_C: `reg_sel`=01, `wb_sel`=00, `w_en`.
  - ADDR: `sel_B`, `en_C`.
  - LD_ADDR: `load_addr`.
  - MEM_RD: `sel_addr`=0.
  - WR_MEM: `sel_addr`=0, `reg_sel`=01, `wb_sel`=11, `w_en`.
  - GET_D: `reg_sel`=01, `en_B`.
  - PASS: `sel_A`, `en_C`.
  - MEM_WR: `sel_addr`=0, `ram_w_en`.
  - HALT: `halted`.
- Transitions:
  - WAIT→RST when `start`=1.
  - RST→FETCH→LOAD_IR→DECODE.
  - DECODE→ MOV imm: WR_IMM; MOV reg: GET_B; ADD/AND/MVN/CMP: GET_A; LDR/STR: GET_A; HALT/illegal: HALT.
  - GET_A→GET_B for ALU ops, →ADDR for LDR/STR.
  - GET_B→EXEC, or →EXEC_CMP for CMP.
  - EXEC→WR_C.
  - ADDR→LD_ADDR.
  - LD_ADDR→MEM_RD (LDR) or →GET_D (STR).
  - MEM_RD→WR_MEM; GET_D→PASS→MEM_WR.
  - WR_IMM, WR_C, EXEC_CMP, WR_MEM, MEM_WR → FETCH.
  - HALT→HALT.
- `start` is ignored outside WAIT. Only `rst_n` leaves HALT.
- `opcode`/`ALU_op` are sampled only in DECODE, GET_A, GET_B and LD_ADDR. The IR is stable at those points.

## Timing
- Reset: state = WAIT immediately on `rst_n` low, independent of `clk`. Outputs while in reset: `waiting`=1, all other outputs 0. Reset mid-instruction aborts the instruction with no further write strobes.
- First fetch: 2 cycles after the `start` edge (RST, then FETCH).
- RAM read latency is 1 cycle. The address is presented in FETCH/MEM_RD, and data is captured in LOAD_IR/WR_MEM.
- Cycles per instruction, FETCH through write-back inclusive:
  - MOV imm: 4
  - MOV reg, CMP: 6
  - ADD/AND/MVN: 7
  - LDR: 8
  - STR: 9
  - HALT: 3 to reach HALT.
- PC increments exactly once per instruction, in LOAD_IR. The PC wraps 0xFF→0x00 in the PC register, not in this block.
- At most one of `w_en`, `ram_w_en`, `en_status` is high in any cycle.

## Structure
- `srm_pkg`: state enum (19 states), opcode/ALU_op constants, `reg_sel` and `wb_sel` encodings. The package is shared with `idecoder` and `datapath`.
- One sub-module is natural: `srm_ctrl_decode`, a combinational state→control-vector decoder. The sequencer holds only the state register and the next-state logic.

## Test plan
- Reset in every state → next cycle `waiting`=1, `halted`=0, all strobes 0. `start` pulse → `clear_pc`&`load_pc` for exactly 1 cycle, then `sel_addr`=1.
- MOV R0,#5 (opcode 110, ALU_op 10) → `w_en` with `wb_sel`=10, `reg_sel`=10 on cycle 4 after FETCH; FETCH on cycle 5.
- ADD (101/00) → `en_A`, `en_B`, `en_C`, then `w_en` with `wb_sel`=00 on cycles 4–7. CMP (101/01) → `en_status` on cycle 6, no `w_en`.
- LDR (011/00) → `sel_B`&`en_C` cycle 5, `load_addr` cycle 6, `sel_addr`=0 cycles 7–8, `w_en` with `wb_sel`=11 cycle 8.
- STR (100/00) → `ram_w_en`=1 only on cycle 9 with `sel_addr`=0; `w_en` never asserted.
- HALT (111) and illegal 011/01 → `halted`=1 from cycle 4 on. No strobes for 50 cycles, and `start` is ignored. `rst_n` low → WAIT.
